// File: rtl/led_pattern_gen_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
//   Shared definitions for the LED pattern generator:
//     led_mode_e  - encoding of the cfg_mode field written by software
//     ch_state_e  - per-channel FSM state
//     DEF_*       - default parameter values
//     ch_width()  - width of the channel index field for a given NUM_CH
// ---------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } led_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ON    = 2'd1,
        ST_BLINK = 2'd2,
        ST_BURST = 2'd3
    } ch_state_e;

    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_PERIOD_W = 16;
    localparam int DEF_COUNT_W  = 8;

    // A single channel still needs a one-bit index field.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// led_pattern_gen_if
//   Configuration write bus of the LED pattern generator.
//     cfg_valid  - write request (master -> slave)
//     cfg_ready  - write accepted when high together with cfg_valid
//     cfg_ch     - target channel index
//     cfg_mode   - 0=OFF, 1=ON, 2=BLINK, 3=BURST
//     cfg_period - clocks per LED half-period (0 treated as 1)
//     cfg_count  - pulses in BURST mode
//     cfg_err    - one-cycle pulse after a write to a non-existent channel
//   Modports: master (software/bench side), slave (generator side).
// ---------------------------------------------------------------------------
interface led_pattern_gen_if import led_pkg::*; #(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int COUNT_W  = DEF_COUNT_W
);
    localparam int CH_W = ch_width(NUM_CH);

    logic                cfg_valid;
    logic                cfg_ready;
    logic [CH_W-1:0]     cfg_ch;
    logic [1:0]          cfg_mode;
    logic [PERIOD_W-1:0] cfg_period;
    logic [COUNT_W-1:0]  cfg_count;
    logic                cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_count,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_count,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/led_channel.sv
// ---------------------------------------------------------------------------
// led_channel
//   One LED channel: mode FSM, half-period counter and toggle counter.
//   Ports:
//     clk, reset            - clock, synchronous active-low reset
//     wr_en                 - configuration write addressed to this channel
//     wr_mode/period/count  - configuration fields of that write
//     led                   - raw (undimmed) LED drive
//     busy                  - channel in BLINK or in a running BURST
//     done                  - one-cycle pulse when a BURST completes
//   A write restarts the channel unconditionally, so it wins over a BURST
//   that would have completed on the same edge.
// ---------------------------------------------------------------------------
module led_channel import led_pkg::*; #(
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int COUNT_W  = DEF_COUNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  led_mode_e           wr_mode,
    input  logic [PERIOD_W-1:0] wr_period,
    input  logic [COUNT_W-1:0]  wr_count,
    output logic                led,
    output logic                busy,
    output logic                done
);

    ch_state_e           state_reg,  state_next;
    logic [PERIOD_W-1:0] hcnt_reg,   hcnt_next;
    logic [PERIOD_W-1:0] period_reg, period_next;
    logic [COUNT_W:0]    tcnt_reg,   tcnt_next;
    logic [COUNT_W-1:0]  count_reg,  count_next;
    logic                led_reg,    led_next;
    logic                done_reg,   done_next;

    logic tick;
    logic last_toggle;

    // period_reg is always >= 1 once BLINK/BURST is entered.
    assign tick        = (hcnt_reg == period_reg - PERIOD_W'(1));
    // A BURST of N pulses is 2*N toggles; this is the last one.
    assign last_toggle = ((tcnt_reg + (COUNT_W+1)'(1)) == {count_reg, 1'b0});

    always_comb begin
        state_next  = state_reg;
        hcnt_next   = hcnt_reg;
        period_next = period_reg;
        tcnt_next   = tcnt_reg;
        count_next  = count_reg;
        led_next    = led_reg;
        done_next   = 1'b0;

        if (wr_en) begin
            hcnt_next   = '0;
            tcnt_next   = '0;
            period_next = (wr_period == '0) ? PERIOD_W'(1) : wr_period;
            count_next  = wr_count;
            led_next    = 1'b0;
            case (wr_mode)
                MODE_OFF:   state_next = ST_IDLE;
                MODE_ON: begin
                    state_next = ST_ON;
                    led_next   = 1'b1;
                end
                MODE_BLINK: state_next = ST_BLINK;
                MODE_BURST: begin
                    // An empty burst completes immediately.
                    if (wr_count == '0) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_BURST;
                    end
                end
                default:    state_next = ST_IDLE;
            endcase
        end else begin
            case (state_reg)
                ST_BLINK: begin
                    if (tick) begin
                        hcnt_next = '0;
                        led_next  = ~led_reg;
                    end else begin
                        hcnt_next = hcnt_reg + PERIOD_W'(1);
                    end
                end
                ST_BURST: begin
                    if (tick) begin
                        hcnt_next = '0;
                        if (last_toggle) begin
                            state_next = ST_IDLE;
                            tcnt_next  = '0;
                            led_next   = 1'b0;
                            done_next  = 1'b1;
                        end else begin
                            tcnt_next = tcnt_reg + (COUNT_W+1)'(1);
                            led_next  = ~led_reg;
                        end
                    end else begin
                        hcnt_next = hcnt_reg + PERIOD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            hcnt_reg   <= '0;
            period_reg <= '0;
            tcnt_reg   <= '0;
            count_reg  <= '0;
            led_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            hcnt_reg   <= hcnt_next;
            period_reg <= period_next;
            tcnt_reg   <= tcnt_next;
            count_reg  <= count_next;
            led_reg    <= led_next;
            done_reg   <= done_next;
        end
    end

    assign led  = led_reg;
    assign done = done_reg;
    assign busy = (state_reg == ST_BLINK) || (state_reg == ST_BURST);

endmodule

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
//   Multi-channel LED pattern generator (OFF / ON / BLINK / BURST).
//   Ports:
//     clk        - rising-edge clock
//     reset      - synchronous, active-low reset
//     cfg        - configuration write bus (led_pattern_gen_if.slave)
//     dim_level  - global brightness 0..15 (only with LED_DIM_EN)
//     led        - LED drive, bit i = channel i
//     busy       - channel in BLINK or running BURST
//     done       - one-cycle pulse when a channel's BURST completes
//   Build option: define LED_DIM_EN to add dim_level and a shared 4-bit
//   free-running PWM counter gating every LED (led = raw & (pwm < dim)).
// ---------------------------------------------------------------------------
module led_pattern_gen import led_pkg::*; #(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int COUNT_W  = DEF_COUNT_W
) (
    input  logic              clk,
    input  logic              reset,
    led_pattern_gen_if.slave  cfg,
`ifdef LED_DIM_EN
    input  logic [3:0]        dim_level,
`endif
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done
);

    localparam int               CH_W       = ch_width(NUM_CH);
    localparam logic [CH_W:0]    NUM_CH_EXT = (CH_W+1)'(NUM_CH);

    logic              accept;
    logic              ch_in_range;
    logic              cfg_err_reg, cfg_err_next;
    logic [NUM_CH-1:0] raw_led;

    // Always ready outside reset; reset itself forces ready low.
    assign cfg.cfg_ready = reset;
    assign accept        = cfg.cfg_valid & cfg.cfg_ready;
    // Extra bit so the comparison also works when NUM_CH is a power of two.
    assign ch_in_range   = ({1'b0, cfg.cfg_ch} < NUM_CH_EXT);
    assign cfg_err_next  = accept & ~ch_in_range;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cfg_err_reg <= 1'b0;
        end else begin
            cfg_err_reg <= cfg_err_next;
        end
    end

    assign cfg.cfg_err = cfg_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic wr_en;
            assign wr_en = accept && ch_in_range && (cfg.cfg_ch == CH_W'(gi));

            led_channel #(
                .PERIOD_W (PERIOD_W),
                .COUNT_W  (COUNT_W)
            ) u_channel (
                .clk       (clk),
                .reset     (reset),
                .wr_en     (wr_en),
                .wr_mode   (led_mode_e'(cfg.cfg_mode)),
                .wr_period (cfg.cfg_period),
                .wr_count  (cfg.cfg_count),
                .led       (raw_led[gi]),
                .busy      (busy[gi]),
                .done      (done[gi])
            );
        end
    endgenerate

`ifdef LED_DIM_EN
    logic [3:0] pwm_cnt_reg, pwm_cnt_next;
    logic       pwm_on;

    assign pwm_cnt_next = pwm_cnt_reg + 4'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pwm_cnt_reg <= 4'd0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_next;
        end
    end

    // dim_level=0 never enables; 15 enables 15 of every 16 cycles.
    assign pwm_on = (pwm_cnt_reg < dim_level);
    assign led    = raw_led & {NUM_CH{pwm_on}};
`else
    assign led = raw_led;
`endif

endmodule
